// File: rtl/m_ext_issue_scheduler.sv
// Round-robin issue scheduler for the shared M-extension lane: one op in flight,
// one-cycle dispatch pulse with zeroed payload when idle, completion index tracking.
//
// state | meaning
// IDLE  | lane free; grant first valid requester at/after rr_ptr when lane is ready
// ISSUE | single cycle driving the dispatch pulse with the captured payload
// WAIT  | op in the lane; leave on completion accepted by the ROB
module m_ext_issue_scheduler #(
    parameter int XLEN                = 64,
    parameter int ROB_INDEX_WIDTH     = 8,
    parameter int DECODED_INSTR_WIDTH = 6,
    parameter int NUM_REQ             = 2
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic                                   flush_i,
    input  logic [NUM_REQ-1:0]                     req_valid_i,
    output logic [NUM_REQ-1:0]                     req_ready_o,
    input  logic [NUM_REQ*XLEN-1:0]                req_1st_reg_i,
    input  logic [NUM_REQ*XLEN-1:0]                req_2nd_reg_i,
    input  logic [NUM_REQ*DECODED_INSTR_WIDTH-1:0] req_op_i,
    input  logic [NUM_REQ*ROB_INDEX_WIDTH-1:0]     req_rob_index_i,
    input  logic                                   lane_ready_i,
    output logic                                   lane_valid_o,
    output logic [XLEN-1:0]                        lane_1st_reg_o,
    output logic [XLEN-1:0]                        lane_2nd_reg_o,
    output logic [DECODED_INSTR_WIDTH-1:0]         lane_op_o,
    output logic [ROB_INDEX_WIDTH-1:0]             lane_rob_index_o,
    input  logic                                   lane_done_valid_i,
    input  logic [ROB_INDEX_WIDTH-1:0]             lane_done_index_i,
    input  logic                                   rob_ready_i,
    output logic                                   busy_o,
    output logic                                   protocol_error_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                     state;
    logic [PTR_W-1:0]           rr_ptr;
    logic [ROB_INDEX_WIDTH-1:0] inflight_rob;

    logic                       grant_any;
    logic [PTR_W-1:0]           grant_idx;
    logic [PTR_W-1:0]           cand_idx;
    logic                       handshake;
    logic                       completion;

    logic [XLEN-1:0]                req_a   [NUM_REQ];
    logic [XLEN-1:0]                req_b   [NUM_REQ];
    logic [DECODED_INSTR_WIDTH-1:0] req_op  [NUM_REQ];
    logic [ROB_INDEX_WIDTH-1:0]     req_rob [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_a[k]   = req_1st_reg_i[k*XLEN +: XLEN];
        assign req_b[k]   = req_2nd_reg_i[k*XLEN +: XLEN];
        assign req_op[k]  = req_op_i[k*DECODED_INSTR_WIDTH +: DECODED_INSTR_WIDTH];
        assign req_rob[k] = req_rob_index_i[k*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH];
    end

    // Scan starts at rr_ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_any && req_valid_i[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign handshake  = (state == IDLE) && lane_ready_i && grant_any && !flush_i && !reset_i;
    assign completion = (state == WAIT) && lane_done_valid_i && rob_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (handshake) begin
            req_ready_o = NUM_REQ'(1) << grant_idx;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            inflight_rob     <= '0;
            lane_valid_o     <= 1'b0;
            lane_1st_reg_o   <= '0;
            lane_2nd_reg_o   <= '0;
            lane_op_o        <= '0;
            lane_rob_index_o <= '0;
            busy_o           <= 1'b0;
            protocol_error_o <= 1'b0;
        end else if (flush_i) begin
            state            <= IDLE;
            lane_valid_o     <= 1'b0;
            lane_1st_reg_o   <= '0;
            lane_2nd_reg_o   <= '0;
            lane_op_o        <= '0;
            lane_rob_index_o <= '0;
            busy_o           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state            <= ISSUE;
                        lane_valid_o     <= 1'b1;
                        lane_1st_reg_o   <= req_a[grant_idx];
                        lane_2nd_reg_o   <= req_b[grant_idx];
                        lane_op_o        <= req_op[grant_idx];
                        lane_rob_index_o <= req_rob[grant_idx];
                        inflight_rob     <= req_rob[grant_idx];
                        busy_o           <= 1'b1;
                        rr_ptr           <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                ISSUE: begin
                    // The lane ORs its inputs, so the payload must drop to zero after the pulse.
                    state            <= WAIT;
                    lane_valid_o     <= 1'b0;
                    lane_1st_reg_o   <= '0;
                    lane_2nd_reg_o   <= '0;
                    lane_op_o        <= '0;
                    lane_rob_index_o <= '0;
                end
                WAIT: begin
                    if (completion) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        if (lane_done_index_i != inflight_rob) begin
                            protocol_error_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_ext_issue_scheduler.sv
// Bench for m_ext_issue_scheduler: directed cycle table, round-robin sequence,
// and a random run against a transaction-level reference model.
module tb_m_ext_issue_scheduler;

    localparam int XLEN = 64;
    localparam int RW   = 8;
    localparam int OW   = 6;
    localparam int NR   = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            flush;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [XLEN-1:0] req_a   [NR];
    logic [XLEN-1:0] req_b   [NR];
    logic [OW-1:0]   req_op  [NR];
    logic [RW-1:0]   req_rob [NR];
    logic [NR*XLEN-1:0] req_1st_flat, req_2nd_flat;
    logic [NR*OW-1:0]   req_op_flat;
    logic [NR*RW-1:0]   req_rob_flat;
    logic            lane_ready;
    logic            lane_valid;
    logic [XLEN-1:0] lane_a, lane_b;
    logic [OW-1:0]   lane_op;
    logic [RW-1:0]   lane_rob;
    logic            done_valid;
    logic [RW-1:0]   done_index;
    logic            rob_ready;
    logic            busy;
    logic            perr;

    assign req_1st_flat = {req_a[1], req_a[0]};
    assign req_2nd_flat = {req_b[1], req_b[0]};
    assign req_op_flat  = {req_op[1], req_op[0]};
    assign req_rob_flat = {req_rob[1], req_rob[0]};

    always #5 clock = ~clock;

    m_ext_issue_scheduler #(
        .XLEN(XLEN), .ROB_INDEX_WIDTH(RW), .DECODED_INSTR_WIDTH(OW), .NUM_REQ(NR)
    ) dut (
        .clock_i(clock), .reset_i(reset), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_1st_reg_i(req_1st_flat), .req_2nd_reg_i(req_2nd_flat),
        .req_op_i(req_op_flat), .req_rob_index_i(req_rob_flat),
        .lane_ready_i(lane_ready), .lane_valid_o(lane_valid),
        .lane_1st_reg_o(lane_a), .lane_2nd_reg_o(lane_b),
        .lane_op_o(lane_op), .lane_rob_index_o(lane_rob),
        .lane_done_valid_i(done_valid), .lane_done_index_i(done_index),
        .rob_ready_i(rob_ready), .busy_o(busy), .protocol_error_o(perr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_fixed_payload();
        req_a[0] = 64'd6;  req_b[0] = 64'd7; req_op[0] = 6'd2; req_rob[0] = 8'd5;
        req_a[1] = 64'd20; req_b[1] = 64'd3; req_op[1] = 6'd5; req_rob[1] = 8'd9;
    endtask

    task automatic check_lane(input string tag, input logic exp_lv, input int src);
        check({tag, "_lane_valid"}, 64'(lane_valid), 64'(exp_lv));
        check({tag, "_lane_a"},   64'(lane_a),   exp_lv ? 64'(req_a[src])   : 64'd0);
        check({tag, "_lane_b"},   64'(lane_b),   exp_lv ? 64'(req_b[src])   : 64'd0);
        check({tag, "_lane_op"},  64'(lane_op),  exp_lv ? 64'(req_op[src])  : 64'd0);
        check({tag, "_lane_rob"}, 64'(lane_rob), exp_lv ? 64'(req_rob[src]) : 64'd0);
    endtask

    typedef struct {
        logic [1:0] rv;
        logic       lr, fl, dv, rr;
        logic [7:0] di;
        logic [1:0] e_rdy;
        logic       e_lv;
        int         e_src;
        logic       e_busy, e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic [1:0] rv, input logic lr, input logic fl, input logic dv,
                       input logic rr, input logic [7:0] di, input logic [1:0] e_rdy,
                       input logic e_lv, input int e_src, input logic e_busy, input logic e_err);
        vec_t v;
        v.rv = rv; v.lr = lr; v.fl = fl; v.dv = dv; v.rr = rr; v.di = di;
        v.e_rdy = e_rdy; v.e_lv = e_lv; v.e_src = e_src; v.e_busy = e_busy; v.e_err = e_err;
        tbl.push_back(v);
    endtask

    // reference model state (transaction level)
    bit          m_busy, m_pulse, m_err;
    int          m_ptr, m_src, ops;
    logic [RW-1:0] m_rob;
    logic [XLEN-1:0] m_a, m_b;
    logic [OW-1:0]   m_op;

    initial begin
        logic [1:0]  gnt;
        logic [1:0]  exp_rdy;
        bit          got, prev_lv, lane_active;
        int          lane_wait, g;
        logic [RW-1:0] lane_tag;

        reset = 1'b1; flush = 1'b0; req_valid = '0; lane_ready = 1'b0;
        done_valid = 1'b0; done_index = '0; rob_ready = 1'b0;
        set_fixed_payload();

        // reset state
        repeat (3) next_cycle();
        req_valid = 2'b01; lane_ready = 1'b1;
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_perr", 64'(perr), 64'd0);
        check_lane("reset", 1'b0, 0);

        //   rv    lr    fl    dv    rr    di     e_rdy e_lv src e_busy e_err
        row(2'b01,1'b1,1'b0,1'b0,1'b0,8'd0, 2'b01,1'b0,0,1'b0,1'b0);
        row(2'b00,1'b1,1'b0,1'b0,1'b0,8'd0, 2'b00,1'b1,0,1'b1,1'b0);
        row(2'b00,1'b1,1'b0,1'b1,1'b1,8'd5, 2'b00,1'b0,0,1'b1,1'b0);
        row(2'b11,1'b0,1'b0,1'b0,1'b0,8'd0, 2'b00,1'b0,0,1'b0,1'b0);
        row(2'b11,1'b1,1'b0,1'b0,1'b0,8'd0, 2'b10,1'b0,0,1'b0,1'b0);
        row(2'b11,1'b1,1'b0,1'b1,1'b1,8'd3, 2'b00,1'b1,1,1'b1,1'b0);
        row(2'b11,1'b1,1'b0,1'b1,1'b0,8'd9, 2'b00,1'b0,0,1'b1,1'b0);
        row(2'b11,1'b1,1'b0,1'b1,1'b0,8'd9, 2'b00,1'b0,0,1'b1,1'b0);
        row(2'b11,1'b1,1'b0,1'b1,1'b0,8'd9, 2'b00,1'b0,0,1'b1,1'b0);
        row(2'b11,1'b1,1'b0,1'b1,1'b0,8'd9, 2'b00,1'b0,0,1'b1,1'b0);
        row(2'b11,1'b1,1'b0,1'b1,1'b1,8'd9, 2'b00,1'b0,0,1'b1,1'b0);
        row(2'b11,1'b1,1'b0,1'b0,1'b0,8'd0, 2'b01,1'b0,0,1'b0,1'b0);
        row(2'b11,1'b1,1'b0,1'b0,1'b0,8'd0, 2'b00,1'b1,0,1'b1,1'b0);
        row(2'b11,1'b1,1'b1,1'b0,1'b0,8'd0, 2'b00,1'b0,0,1'b1,1'b0);
        row(2'b10,1'b1,1'b0,1'b0,1'b0,8'd0, 2'b10,1'b0,0,1'b0,1'b0);
        row(2'b00,1'b1,1'b0,1'b0,1'b0,8'd0, 2'b00,1'b1,1,1'b1,1'b0);
        row(2'b00,1'b1,1'b0,1'b1,1'b1,8'd10,2'b00,1'b0,0,1'b1,1'b0);
        row(2'b00,1'b1,1'b0,1'b0,1'b0,8'd0, 2'b00,1'b0,0,1'b0,1'b1);
        row(2'b01,1'b1,1'b1,1'b0,1'b0,8'd0, 2'b00,1'b0,0,1'b0,1'b1);
        row(2'b00,1'b1,1'b0,1'b0,1'b0,8'd0, 2'b00,1'b0,0,1'b0,1'b1);

        foreach (tbl[i]) begin
            next_cycle();
            reset = 1'b0;
            req_valid = tbl[i].rv; lane_ready = tbl[i].lr; flush = tbl[i].fl;
            done_valid = tbl[i].dv; rob_ready = tbl[i].rr; done_index = tbl[i].di;
            #1;
            check($sformatf("tbl%0d_req_ready", i), 64'(req_ready), 64'(tbl[i].e_rdy));
            check_lane($sformatf("tbl%0d", i), tbl[i].e_lv, tbl[i].e_src);
            check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
            check($sformatf("tbl%0d_perr", i), 64'(perr), 64'(tbl[i].e_err));
        end

        // sticky error cleared only by reset
        next_cycle();
        reset = 1'b1; flush = 1'b0; done_valid = 1'b0; req_valid = 2'b11; lane_ready = 1'b1;
        #1;
        check("rst2_req_ready", 64'(req_ready), 64'd0);
        next_cycle();
        #1;
        check("rst2_perr", 64'(perr), 64'd0);
        check("rst2_busy", 64'(busy), 64'd0);

        // round-robin: both requesters valid, completion 3 cycles after issue
        for (int op = 0; op < 8; op++) begin
            got = 1'b0; gnt = '0;
            for (int w = 0; w < 10 && !got; w++) begin
                next_cycle();
                reset = 1'b0; done_valid = 1'b0; rob_ready = 1'b0;
                #1;
                if (req_ready != 2'b00) begin got = 1'b1; gnt = req_ready; end
            end
            check($sformatf("rr%0d_granted", op), 64'(got), 64'd1);
            check($sformatf("rr%0d_grant", op), 64'(gnt), (op % 2 == 0) ? 64'd1 : 64'd2);
            next_cycle();
            #1;
            check($sformatf("rr%0d_pulse", op), 64'(lane_valid), 64'd1);
            next_cycle();
            next_cycle();
            next_cycle();
            done_valid = 1'b1; rob_ready = 1'b1;
            done_index = (gnt == 2'b01) ? 8'd5 : 8'd9;
            #1;
        end
        check("rr_no_error", 64'(perr), 64'd0);

        // random run against the reference model
        next_cycle();
        reset = 1'b1; done_valid = 1'b0; flush = 1'b0;
        next_cycle();
        reset = 1'b0;
        m_busy = 0; m_pulse = 0; m_err = 0; m_ptr = 0; m_src = 0; ops = 0;
        m_rob = '0; m_a = '0; m_b = '0; m_op = '0;
        prev_lv = 0; lane_active = 0; lane_wait = 0; lane_tag = '0;
        for (int cyc = 0; cyc < 4000 && ops < 100; cyc++) begin
            if (cyc > 0) next_cycle();
            for (int k = 0; k < NR; k++) begin
                req_a[k] = {$urandom, $urandom}; req_b[k] = {$urandom, $urandom};
                req_op[k] = OW'($urandom); req_rob[k] = RW'($urandom);
            end
            req_valid  = NR'($urandom);
            lane_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 40) == 0);
            rob_ready  = ($urandom_range(0, 3) != 0);
            if (lane_valid) begin
                lane_active = 1'b1;
                lane_wait   = $urandom_range(1, 4);
                lane_tag    = lane_rob;
            end else if (lane_wait > 0) begin
                lane_wait--;
            end
            if (lane_active && !lane_valid) begin
                done_valid = (lane_wait == 0);
                done_index = ($urandom_range(0, 60) == 0) ? lane_tag + 8'd1 : lane_tag;
            end else begin
                done_valid = ($urandom_range(0, 7) == 0);
                done_index = RW'($urandom);
            end
            #1;
            g = -1;
            if (!m_busy && lane_ready && !flush) begin
                for (int i = 0; i < NR; i++) begin
                    if (g < 0 && req_valid[(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
                end
            end
            exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
            check("rnd_req_ready", 64'(req_ready), 64'(exp_rdy));
            check("rnd_lane_valid", 64'(lane_valid), 64'(m_pulse));
            check("rnd_lane_a",   64'(lane_a),   m_pulse ? 64'(m_a)   : 64'd0);
            check("rnd_lane_b",   64'(lane_b),   m_pulse ? 64'(m_b)   : 64'd0);
            check("rnd_lane_op",  64'(lane_op),  m_pulse ? 64'(m_op)  : 64'd0);
            check("rnd_lane_rob", 64'(lane_rob), m_pulse ? 64'(m_rob) : 64'd0);
            check("rnd_busy", 64'(busy), 64'(m_busy));
            check("rnd_perr", 64'(perr), 64'(m_err));
            check("rnd_no_back_to_back", 64'(lane_valid && prev_lv), 64'd0);
            prev_lv = lane_valid;

            if (flush) begin
                m_busy = 0; m_pulse = 0;
            end else begin
                if (m_pulse) begin
                    m_pulse = 0;
                end else if (m_busy && done_valid && rob_ready) begin
                    m_busy = 0;
                    if (done_index != m_rob) m_err = 1;
                end
                if (g >= 0) begin
                    m_busy = 1; m_pulse = 1; m_src = g;
                    m_a = req_a[g]; m_b = req_b[g]; m_op = req_op[g]; m_rob = req_rob[g];
                    m_ptr = (g + 1) % NR;
                    ops++;
                end
            end
            if (flush || (lane_active && !lane_valid && done_valid && rob_ready)) begin
                lane_active = 1'b0;
                lane_wait = 0;
            end
        end
        check("rnd_ops_reached", 64'(ops >= 100), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
